// File: rtl/llm_quant_pkg.sv
// rtl/llm_quant_pkg.sv - shared types and constants for the symmetric int quantizer
package llm_quant_pkg;

  typedef enum logic [1:0] {FILL, RECIP, DRAIN} state_t;

  localparam int QUANT_MAX = 127;
  localparam int DEFAULT_RECIP_FRAC_WIDTH = 16;

  // Integer bits of 127/max_num plus its fraction bits.
  function automatic int recip_width(input int quant_width, input int recip_frac_width);
    return quant_width - 1 + recip_frac_width;
  endfunction

endpackage

// File: rtl/fixed_serial_divider.sv
// rtl/fixed_serial_divider.sv - unsigned restoring divider, one quotient bit per cycle
module fixed_serial_divider #(
  parameter int NUM_WIDTH = 23,
  parameter int DEN_WIDTH = 16,
  parameter int Q_WIDTH   = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_WIDTH-1:0] num,
  input  logic [DEN_WIDTH-1:0] den,
  output logic [Q_WIDTH-1:0]   quotient,
  output logic                 done
);

  localparam int CW = $clog2(Q_WIDTH + 1);

  logic [DEN_WIDTH-1:0] rem;
  logic [DEN_WIDTH-1:0] den_q;
  logic [NUM_WIDTH-1:0] num_sr;
  logic [Q_WIDTH-1:0]   quo;
  logic [CW-1:0]        count;
  logic                 busy;
  logic [DEN_WIDTH:0]   trial;
  logic [DEN_WIDTH:0]   diff;
  logic                 fits;

  assign trial = {rem, num_sr[NUM_WIDTH-1]};
  assign diff  = trial - {1'b0, den_q};
  assign fits  = trial >= {1'b0, den_q};

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem    <= '0;
      den_q  <= '0;
      num_sr <= '0;
      quo    <= '0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        den_q  <= den;
        rem    <= '0;
        num_sr <= num;
        quo    <= '0;
        count  <= CW'(Q_WIDTH);
        busy   <= 1'b1;
      end else if (busy) begin
        rem    <= fits ? diff[DEN_WIDTH-1:0] : trial[DEN_WIDTH-1:0];
        num_sr <= {num_sr[NUM_WIDTH-2:0], 1'b0};
        quo    <= {quo[Q_WIDTH-2:0], fits};
        count  <= count - CW'(1);
        if (count == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // A zero divisor runs the same number of cycles but reports a zero quotient.
  assign quotient = (den_q == '0) ? '0 : quo;

endmodule

// File: rtl/block_quantizer.sv
// rtl/block_quantizer.sv - buffers a block, finds max |x|, emits round(x*127/max) as signed ints
module block_quantizer
  import llm_quant_pkg::*;
#(
  parameter int IN_WIDTH           = 16,
  parameter int IN_FRAC_WIDTH      = 8,
  parameter int IN_SIZE            = 4,
  parameter int IN_PARALLELISM     = 1,
  parameter int IN_DEPTH           = 4,
  parameter int QUANTIZATION_WIDTH = 8,
  parameter int MAX_NUM_WIDTH      = IN_WIDTH,
  parameter int RECIP_FRAC_WIDTH   = DEFAULT_RECIP_FRAC_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic signed [IN_WIDTH-1:0]           data_in [IN_PARALLELISM*IN_SIZE],
  input  logic                                 data_in_valid,
  output logic                                 data_in_ready,
  output logic signed [QUANTIZATION_WIDTH-1:0] data_out [IN_PARALLELISM*IN_SIZE],
  output logic [MAX_NUM_WIDTH-1:0]             max_num,
  output logic                                 data_out_valid,
  input  logic                                 data_out_ready
);

  localparam int N     = IN_PARALLELISM * IN_SIZE;
  localparam int QW    = QUANTIZATION_WIDTH;
  localparam int RW    = recip_width(QUANTIZATION_WIDTH, RECIP_FRAC_WIDTH);
  localparam int PW    = IN_WIDTH + RW + 1;
  localparam int CNT_W = $clog2(IN_DEPTH + 1);
  localparam int IDX_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

  localparam logic [RW-1:0]        RECIP_NUM  = RW'(QUANT_MAX) << RECIP_FRAC_WIDTH;
  localparam logic signed [PW-1:0] ROUND_HALF = PW'(1) <<< (RECIP_FRAC_WIDTH - 1);
  localparam logic signed [PW-1:0] Q_HI       = PW'(QUANT_MAX);
  localparam logic signed [PW-1:0] Q_LO       = PW'(-QUANT_MAX);

  state_t state, state_next;

  logic signed [IN_WIDTH-1:0] buffer [IN_DEPTH][N];
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          idx;
  logic [MAX_NUM_WIDTH-1:0]  run_max, beat_max;
  logic [RW-1:0]             recip;
  logic                      accept, last_in, last_out;
  logic                      div_start, div_started, div_done;
  logic                      unused_frac;

  // Fraction bits cancel in x/max_num, so the input scaling never enters the datapath.
  assign unused_frac = (IN_FRAC_WIDTH > 0);

  function automatic logic [MAX_NUM_WIDTH-1:0] abs_mag(input logic signed [IN_WIDTH-1:0] x);
    return x[IN_WIDTH-1] ? MAX_NUM_WIDTH'($unsigned(-x)) : MAX_NUM_WIDTH'($unsigned(x));
  endfunction

  function automatic logic signed [QW-1:0] quantize(input logic signed [IN_WIDTH-1:0] x,
                                                     input logic [RW-1:0] r);
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] q;
    prod = PW'(x) * $signed(PW'(r));
    q    = (prod + ROUND_HALF) >>> RECIP_FRAC_WIDTH;
    if (q > Q_HI)      q = Q_HI;
    else if (q < Q_LO) q = Q_LO;
    return q[QW-1:0];
  endfunction

  assign idx      = cnt[IDX_W-1:0];
  assign accept   = data_in_valid && data_in_ready;
  assign last_in  = accept && (cnt == CNT_W'(IN_DEPTH - 1));
  assign last_out = (state == DRAIN) && data_out_valid && data_out_ready && (cnt == CNT_W'(IN_DEPTH));

  always_comb begin
    beat_max = run_max;
    for (int i = 0; i < N; i++) begin
      if (abs_mag(data_in[i]) > beat_max) beat_max = abs_mag(data_in[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= FILL;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (last_in)  state_next = RECIP;
      RECIP:   if (div_done) state_next = DRAIN;
      DRAIN:   if (last_out) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    data_in_ready = (state == FILL);
    div_start     = (state == RECIP) && !div_started;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N; i++) buffer[idx][i] <= data_in[i];
    end
  end

  // Beat 0 is loaded on the divider's done cycle so DRAIN opens with valid already high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt            <= '0;
      run_max        <= '0;
      max_num        <= '0;
      data_out_valid <= 1'b0;
      div_started    <= 1'b0;
      for (int i = 0; i < N; i++) data_out[i] <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            run_max <= beat_max;
            if (last_in) begin
              max_num <= beat_max;
              cnt     <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        RECIP: begin
          if (div_start) div_started <= 1'b1;
          if (div_done) begin
            div_started    <= 1'b0;
            data_out_valid <= 1'b1;
            cnt            <= CNT_W'(1);
            for (int i = 0; i < N; i++) data_out[i] <= quantize(buffer[0][i], recip);
          end
        end
        DRAIN: begin
          if (data_out_valid && data_out_ready) begin
            if (cnt == CNT_W'(IN_DEPTH)) begin
              data_out_valid <= 1'b0;
              cnt            <= '0;
              run_max        <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
              for (int i = 0; i < N; i++) data_out[i] <= quantize(buffer[idx][i], recip);
            end
          end
        end
        default: ;
      endcase
    end
  end

  fixed_serial_divider #(
    .NUM_WIDTH(RW),
    .DEN_WIDTH(MAX_NUM_WIDTH),
    .Q_WIDTH  (RW)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .num     (RECIP_NUM),
    .den     (max_num),
    .quotient(recip),
    .done    (div_done)
  );

endmodule

// File: tb/tb_block_quantizer.sv
// tb/tb_block_quantizer.sv - directed and table-driven checks for block_quantizer
module tb_block_quantizer;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int D  = 2;
  localparam int QW = 8;

  typedef struct {
    int din[D*N];
    int exp_max;
    int exp_q[D*N];
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic signed [W-1:0]  data_in [N];
  logic                 data_in_valid, data_in_ready;
  logic signed [QW-1:0] data_out [N];
  logic [W-1:0]         max_num;
  logic                 data_out_valid, data_out_ready;

  block_quantizer #(
    .IN_WIDTH(16), .IN_FRAC_WIDTH(8), .IN_SIZE(4), .IN_PARALLELISM(1), .IN_DEPTH(2),
    .QUANTIZATION_WIDTH(8), .MAX_NUM_WIDTH(16), .RECIP_FRAC_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .data_out(data_out), .max_num(max_num),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_edge = 0;
  int got_q[D][N];
  int got_m[D];
  int got_n;
  vec_t vecs[6];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (data_in_valid && data_in_ready) acc_edge <= cyc + 1;
  end

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N*QW-1:0] pack_out();
    logic [N*QW-1:0] p;
    for (int i = 0; i < N; i++) p[i*QW +: QW] = data_out[i];
    return p;
  endfunction

  function automatic int q_model(input int x, input int m);
    longint r, p, q;
    if (m == 0) return 0;
    r = (longint'(127) << 16) / m;
    p = longint'(x) * r + 32768;
    q = p >>> 16;
    if (q > 127) q = 127;
    if (q < -127) q = -127;
    return int'(q);
  endfunction

  task automatic send_block(input int din[D*N], input bit gaps);
    for (int b = 0; b < D; b++) begin
      int t;
      t = 0;
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      for (int i = 0; i < N; i++) data_in[i] = 16'(din[b*N+i]);
      data_in_valid = 1'b1;
      while (!data_in_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!data_in_ready) check("send_timeout", 0, 1);
      @(negedge clk);
      data_in_valid = 1'b0;
    end
  endtask

  // mode 0: always ready, 1: five-cycle stall after beat 0, 2: random ready
  task automatic recv_block(input int mode, input bit chk_lat);
    int t, stall;
    bit seen, held;
    logic [N*QW-1:0] hd;
    logic [W-1:0] hm;
    t = 0; stall = 0; seen = 0; held = 0; got_n = 0;
    while (got_n < D && t < 300) begin
      @(negedge clk);
      t++;
      if (held) begin
        check("hold_data", pack_out(), hd);
        check("hold_max", max_num, hm);
        check("hold_valid", data_out_valid, 1);
      end
      if (data_out_valid && !seen) begin
        seen = 1;
        if (chk_lat) check("latency", cyc - acc_edge, 25);
      end
      case (mode)
        1: if (got_n == 1 && stall < 5) begin data_out_ready = 1'b0; stall++; end
           else data_out_ready = 1'b1;
        2: data_out_ready = 1'($urandom_range(0, 1));
        default: data_out_ready = 1'b1;
      endcase
      held = data_out_valid && !data_out_ready;
      hd = pack_out();
      hm = max_num;
      if (data_out_valid && data_out_ready) begin
        check("out_known", $isunknown(pack_out()), 0);
        check("in_ready_low", data_in_ready, 0);
        for (int i = 0; i < N; i++) got_q[got_n][i] = data_out[i];
        got_m[got_n] = max_num;
        got_n++;
      end
    end
    if (got_n < D) check("recv_timeout", got_n, D);
    @(negedge clk);
    data_out_ready = 1'b1;
    check("valid_drop", data_out_valid, 0);
    check("in_ready_back", data_in_ready, 1);
  endtask

  task automatic expect_block(input string tag, input int exp_m, input int exp_q[D*N]);
    for (int b = 0; b < D; b++) begin
      check($sformatf("%s_max%0d", tag, b), got_m[b], exp_m);
      for (int i = 0; i < N; i++)
        check($sformatf("%s_q%0d_%0d", tag, b, i), got_q[b][i], exp_q[b*N+i]);
    end
  endtask

  task automatic model_block(input int din[D*N], output int exp_m, output int exp_q[D*N]);
    exp_m = 0;
    for (int k = 0; k < D*N; k++) begin
      int a;
      a = (din[k] < 0) ? -din[k] : din[k];
      if (a > exp_m) exp_m = a;
    end
    for (int k = 0; k < D*N; k++) exp_q[k] = q_model(din[k], exp_m);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check({tag, "_valid"}, data_out_valid, 0);
    check({tag, "_in_ready"}, data_in_ready, 1);
    check({tag, "_max"}, max_num, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ra[D*N], rb[D*N], ea[D*N], eb[D*N];
    int ma, mb, t;
    logic signed [15:0] r16;

    vecs[0] = '{'{256, -128, 64, 0, 0, 0, 0, 0}, 256, '{127, -63, 32, 0, 0, 0, 0, 0}};
    vecs[1] = '{'{0, 0, 0, 0, 0, 0, 0, 0}, 0, '{0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[2] = '{'{-32768, 0, 0, 0, 0, 0, 0, 0}, 32768, '{-127, 0, 0, 0, 0, 0, 0, 0}};
    vecs[3] = '{'{100, -100, 50, -50, 25, 0, 1, -1}, 100, '{127, -127, 63, -63, 32, 0, 1, -1}};
    vecs[4] = '{'{10, 20, -30, 0, 3, 3, 3, -40}, 40, '{32, 63, -95, 0, 10, 10, 10, -127}};
    vecs[5] = '{'{32767, -32767, 1, -1, 0, 0, 0, 0}, 32767, '{127, -127, 0, 0, 0, 0, 0, 0}};

    rst = 1'b0;
    data_in_valid = 1'b0;
    data_out_ready = 1'b1;
    for (int i = 0; i < N; i++) data_in[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", data_in_ready, 1);
    check("rst_out_valid", data_out_valid, 0);
    check("rst_max", max_num, 0);
    check("rst_data", pack_out(), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      fork
        send_block(vecs[v].din, 1'b0);
        recv_block(0, 1'b1);
      join
      expect_block($sformatf("vec%0d", v), vecs[v].exp_max, vecs[v].exp_q);
    end

    fork
      send_block(vecs[3].din, 1'b0);
      recv_block(1, 1'b1);
    join
    expect_block("stall", vecs[3].exp_max, vecs[3].exp_q);

    send_block(vecs[0].din, 1'b0);
    repeat (4) @(negedge clk);
    pulse_reset("rst_recip");

    data_out_ready = 1'b0;
    send_block(vecs[3].din, 1'b0);
    t = 0;
    while (!data_out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_reached", data_out_valid, 1);
    pulse_reset("rst_drain");
    data_out_ready = 1'b1;

    fork
      send_block(vecs[4].din, 1'b0);
      recv_block(0, 1'b1);
    join
    expect_block("after_rst", vecs[4].exp_max, vecs[4].exp_q);

    for (int k = 0; k < D*N; k++) begin
      r16 = 16'($urandom);
      ra[k] = r16;
      rb[k] = int'($urandom_range(0, 600)) - 300;
    end
    model_block(ra, ma, ea);
    model_block(rb, mb, eb);
    fork
      begin
        send_block(ra, 1'b1);
        send_block(rb, 1'b1);
      end
      begin
        recv_block(2, 1'b1);
        expect_block("rand_a", ma, ea);
        recv_block(2, 1'b1);
        expect_block("rand_b", mb, eb);
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
